// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage bus initiator. Takes one load/store from the pipeline
// and issues it as a valid/ready transaction to a variable-latency data memory.
// It formats store byte lanes, extends load data and stalls the pipeline until
// the access completes.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word
// accesses (pulse misalign, no bus request). When it is undefined, the low address
// bits are dropped per access size.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        Ctl_MemRead_in,
    input  logic        Ctl_MemWrite_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] ALUresult_in,
    input  logic [31:0] Write_Data,
    output logic        stall,
    output logic [31:0] Read_Data,
    output logic        rdata_valid,
    output logic        misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_t;

    state_t      state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;

    logic        op;
    logic        misaligned;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt;
    logic [31:0] rdata_shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign op    = Ctl_MemRead_in | Ctl_MemWrite_in;
    // DONE releases the pipeline for exactly one cycle so the op is not re-issued
    assign stall = op & (state_q != StDone);

`ifdef LSU_MISALIGN_TRAP_EN
    // funct3[1:0]: 00 byte, 01 half, 10/11 word
    assign misaligned = ((funct3_in[1:0] == 2'b01) & ALUresult_in[0]) |
                        (funct3_in[1] & (ALUresult_in[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Byte-lane enables and lane-replicated store data from the request
    always_comb begin
        be_fmt    = 4'b1111;
        wdata_fmt = Write_Data;
        case (funct3_in[1:0])
            2'b00: begin
                be_fmt    = 4'b0001 << ALUresult_in[1:0];
                wdata_fmt = {4{Write_Data[7:0]}};
            end
            2'b01: begin
                be_fmt    = 4'b0011 << {ALUresult_in[1], 1'b0};
                wdata_fmt = {2{Write_Data[15:0]}};
            end
            default: begin
                be_fmt    = 4'b1111;
                wdata_fmt = Write_Data;
            end
        endcase
    end

    // Select and extend the loaded byte/half using the latched offset and size
    always_comb begin
        rdata_shifted = mem_rdata >> {offset_q, 3'b000};
        byte_sel      = rdata_shifted[7:0];
        half_sel      = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h000000, byte_sel};
            3'b101:  load_ext = {16'h0000, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    // Access FSM with registered bus and result outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            funct3_q    <= 3'b000;
            offset_q    <= 2'b00;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_be      <= 4'h0;
            mem_wdata   <= 32'h0;
            Read_Data   <= 32'h0;
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (op) begin
                        if (misaligned) begin
                            misalign <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            funct3_q  <= funct3_in;
                            offset_q  <= ALUresult_in[1:0];
                            // store wins when both requests are raised
                            mem_we    <= Ctl_MemWrite_in;
                            mem_addr  <= {ALUresult_in[31:2], 2'b00};
                            mem_be    <= be_fmt;
                            mem_wdata <= wdata_fmt;
                            mem_req   <= 1'b1;
                            state_q   <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state_q <= mem_we ? StDone : StWait;
                    end
                end
                StWait: begin
                    if (mem_rvalid) begin
                        Read_Data   <= load_ext;
                        rdata_valid <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, reset corner cases and
// randomized accesses against a byte-lane arithmetic reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Ctl_MemRead_in = 1'b0;
    logic        Ctl_MemWrite_in = 1'b0;
    logic [2:0]  funct3_in = 3'b000;
    logic [31:0] ALUresult_in = 32'h0;
    logic [31:0] Write_Data = 32'h0;
    logic        stall;
    logic [31:0] Read_Data;
    logic        rdata_valid;
    logic        misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] rd_model = 32'h0;

    load_store_unit dut (
        .clk            (clk),
        .reset          (reset),
        .Ctl_MemRead_in (Ctl_MemRead_in),
        .Ctl_MemWrite_in(Ctl_MemWrite_in),
        .funct3_in      (funct3_in),
        .ALUresult_in   (ALUresult_in),
        .Write_Data     (Write_Data),
        .stall          (stall),
        .Read_Data      (Read_Data),
        .rdata_valid    (rdata_valid),
        .misalign       (misalign),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gd;
        int          rvd;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] bus_wdata;
        logic [31:0] load;
        int          stall_cycles;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic is_trap(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
        int size;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        return (addr % size) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: sizes in bytes, lane positions and masks by plain arithmetic
    function automatic vec_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input int gd, input int rvd, input logic [31:0] rdata);
        vec_t v;
        int n;
        int start;
        logic [31:0] mask;
        logic [31:0] val;
        n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        start = (n == 1) ? int'(addr % 4) : (n == 2) ? int'((addr % 4) / 2 * 2) : 0;
        mask  = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.gd = gd; v.rvd = rvd; v.rdata = rdata;
        v.be = 4'(((32'd1 << n) - 32'd1) << start);
        if (n == 1)      v.bus_wdata = (wdata & 32'hFF) * 32'h0101_0101;
        else if (n == 2) v.bus_wdata = (wdata & 32'hFFFF) * 32'h0001_0001;
        else             v.bus_wdata = wdata;
        val = (rdata >> (8 * start)) & mask;
        if (n < 4 && !f3[2] && val[8 * n - 1]) val = val | ~mask;
        v.load = val;
        v.stall_cycles = wr ? 2 + gd : 3 + gd + rvd;
        return v;
    endfunction

    function automatic vec_t tv(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int gd, input int rvd, input logic [31:0] rdata,
                                input logic [3:0] be, input logic [31:0] bus_wdata,
                                input logic [31:0] load, input int stall_cycles);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.gd = gd; v.rvd = rvd; v.rdata = rdata; v.be = be; v.bus_wdata = bus_wdata;
        v.load = load; v.stall_cycles = stall_cycles;
        return v;
    endfunction

    task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd);
        Ctl_MemRead_in  = rd;
        Ctl_MemWrite_in = wr;
        funct3_in       = f3;
        ALUresult_in    = addr;
        Write_Data      = wd;
    endtask

    // Run one access as the pipeline plus a memory responder, checking every cycle
    task automatic do_access(input vec_t v);
        logic trap;
        logic is_load;
        int   n_stall;
        int   req_cyc;
        int   wait_cyc;
        logic granted;
        logic done;
        trap     = is_trap(v.f3, v.addr);
        is_load  = v.rd && !v.wr;
        n_stall  = 0;
        req_cyc  = 0;
        wait_cyc = 0;
        granted  = 1'b0;
        done     = 1'b0;
        @(negedge clk);
        drive_op(v.rd, v.wr, v.f3, v.addr, v.wdata);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        chk("rdata_valid_pulse_end", {31'b0, rdata_valid}, 32'd0);
        chk("misalign_pulse_end", {31'b0, misalign}, 32'd0);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                mem_gnt    = 1'b0;
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
                #1;
            end
            if (!stall) begin
                done = 1'b1;
                chk("stall_cycles", n_stall, trap ? 32'd1 : v.stall_cycles);
                chk("rdata_valid", {31'b0, rdata_valid}, {31'b0, is_load && !trap});
                chk("misalign", {31'b0, misalign}, {31'b0, trap});
                chk("mem_req_in_done", {31'b0, mem_req}, 32'd0);
                if (is_load && !trap) rd_model = v.load;
                chk("Read_Data", Read_Data, rd_model);
                drive_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            end else begin
                n_stall++;
                if (mem_req) begin
                    chk("req_on_misaligned", {31'b0, trap}, 32'd0);
                    chk("mem_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
                    chk("mem_be", {28'b0, mem_be}, {28'b0, v.be});
                    chk("mem_we", {31'b0, mem_we}, {31'b0, v.wr});
                    if (v.wr) chk("mem_wdata", mem_wdata, v.bus_wdata);
                    if (req_cyc == v.gd) begin
                        mem_gnt = 1'b1;
                        granted = 1'b1;
                    end else begin
                        // rvalid before the grant must be ignored
                        mem_rvalid = 1'b1;
                    end
                    req_cyc++;
                end else if (granted) begin
                    if (wait_cyc == v.rvd) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = v.rdata;
                    end
                    wait_cyc++;
                end
            end
        end
        if (!done) begin
            chk("access_timeout", 32'd1, 32'd0);
            drive_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        chk("stall_idle", {31'b0, stall}, 32'd0);
        chk("mem_req_idle", {31'b0, mem_req}, 32'd0);
    endtask

    // After reset: feed stray rvalids and confirm nothing is captured
    task automatic late_rvalid_check(input string tag);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h8765_4321;
            #1;
            chk({tag, "_rdata_valid"}, {31'b0, rdata_valid}, 32'd0);
            chk({tag, "_Read_Data"}, Read_Data, 32'd0);
            chk({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    vec_t table_v[$];
    vec_t rv;

    initial begin
        // Directed vectors: rd, wr, f3, addr, wdata, gnt delay, rvalid delay, rdata,
        // expected be, bus wdata, load result, stall cycles
        table_v.push_back(tv(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0,
                             4'b1111, 32'hDEADBEEF, 32'h0, 2));
        table_v.push_back(tv(0, 1, 3'b000, 32'h103, 32'h123456A5, 0, 0, 32'h0,
                             4'b1000, 32'hA5A5A5A5, 32'h0, 2));
        table_v.push_back(tv(1, 0, 3'b000, 32'h103, 32'h0, 0, 0, 32'hA5000000,
                             4'b1000, 32'h0, 32'hFFFFFFA5, 3));
        table_v.push_back(tv(1, 0, 3'b100, 32'h103, 32'h0, 0, 0, 32'hA5000000,
                             4'b1000, 32'h0, 32'h000000A5, 3));
        table_v.push_back(tv(1, 0, 3'b001, 32'h102, 32'h0, 3, 2, 32'h80010000,
                             4'b1100, 32'h0, 32'hFFFF8001, 8));
        table_v.push_back(tv(1, 1, 3'b010, 32'h200, 32'h11223344, 1, 0, 32'h0,
                             4'b1111, 32'h11223344, 32'h0, 3));
        table_v.push_back(tv(1, 0, 3'b010, 32'h101, 32'h0, 0, 0, 32'hCAFEF00D,
                             4'b1111, 32'h0, 32'hCAFEF00D, 3));
        table_v.push_back(tv(1, 0, 3'b101, 32'h106, 32'h0, 0, 1, 32'h8001ABCD,
                             4'b1100, 32'h0, 32'h00008001, 4));
        table_v.push_back(tv(0, 1, 3'b001, 32'h0FE, 32'hAAAA5678, 2, 0, 32'h0,
                             4'b1100, 32'h56785678, 32'h0, 4));
        table_v.push_back(tv(1, 0, 3'b000, 32'h000, 32'h0, 0, 0, 32'h0000007F,
                             4'b0001, 32'h0, 32'h0000007F, 3));
        table_v.push_back(tv(1, 0, 3'b010, 32'h040, 32'h0, 0, 0, 32'h12345678,
                             4'b1111, 32'h0, 32'h12345678, 3));

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_Read_Data", Read_Data, 32'd0);
        chk("rst_rdata_valid", {31'b0, rdata_valid}, 32'd0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        reset = 1'b1;

        foreach (table_v[i]) do_access(table_v[i]);
        idle_cycle();

        // Reset while a read waits for its grant: mem_req drops asynchronously
        @(negedge clk);
        drive_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        @(negedge clk);
        #1;
        chk("rq_mem_req_before_reset", {31'b0, mem_req}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rq_mem_req_async_drop", {31'b0, mem_req}, 32'd0);
        chk("rq_Read_Data_cleared", Read_Data, 32'd0);
        rd_model = 32'h0;
        drive_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        late_rvalid_check("rq_late");

        // Put a nonzero value in Read_Data, then reset while in WAIT
        do_access(model(1, 0, 3'b010, 32'h44, 32'h0, 0, 0, 32'h0BADF00D));
        @(negedge clk);
        drive_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0);
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        chk("wt_mem_req_in_req", {31'b0, mem_req}, 32'd1);
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        chk("wt_mem_req_in_wait", {31'b0, mem_req}, 32'd0);
        chk("wt_stall_in_wait", {31'b0, stall}, 32'd1);
        reset = 1'b0;
        #1;
        chk("wt_Read_Data_cleared", Read_Data, 32'd0);
        rd_model = 32'h0;
        drive_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        late_rvalid_check("wt_late");

        // Randomized accesses against the reference model
        for (int i = 0; i < 80; i++) begin
            logic rd;
            logic wr;
            int   kind;
            kind = int'($urandom_range(0, 2));
            rd   = (kind != 1);
            wr   = (kind != 0);
            rv = model(rd, wr, 3'($urandom), $urandom, $urandom,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
            do_access(rv);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Bus-side initiator for the MEM stage: takes load/store requests from the pipeline and issues them as valid/ready transactions to an external data memory with variable latency. It formats store byte lanes, sign/zero-extends load data and stalls the pipeline until each access completes. It sits between the EX/MEM pipeline register and the data memory port.

## Interface
- No parameters; data/address widths fixed at 32 bits.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- Ctl_MemRead_in  in  1  load request from EX/MEM
- Ctl_MemWrite_in  in  1  store request from EX/MEM
- funct3_in  in  3  access size/sign (RV32I load/store funct3)
- ALUresult_in  in  32  byte address
- Write_Data  in  32  store data, right-aligned
- stall  out  1  hold pipeline; combinational
- Read_Data  out  32  extended load result, registered
- rdata_valid  out  1  one-cycle pulse, Read_Data valid
- misalign  out  1  one-cycle pulse, access rejected (only with LSU_MISALIGN_TRAP_EN)
- mem_req  out  1  bus request, registered
- mem_we  out  1  1 = write
- mem_addr  out  32  word address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data word

## Operation
- FSM: IDLE, REQ, WAIT, DONE.
- IDLE: op = MemRead|MemWrite. If op: latch addr, be, wdata, we, funct3, addr[1:0]; go REQ. MemWrite wins when both asserted.
- REQ: mem_req=1; address/be/wdata/we held stable until mem_gnt. On gnt: write→DONE, read→WAIT.
- WAIT: mem_rvalid ignored in REQ; on mem_rvalid, capture extended data into Read_Data; →DONE.
- DONE: rdata_valid=1 for reads; →IDLE unconditionally.
- stall = op & (state != DONE). stall=0 in DONE lets the pipeline advance; no re-issue of the same op.
- Stores: SB be=4'b0001<<addr[1:0], wdata={4{b}}; SH be=4'b0011<<{addr[1],1'b0}, wdata={2{h}}; SW be=4'b1111.
- Loads: byte/half selected by latched addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
- funct3 011/110/111 treated as word access.
- mem_be=0 for reads is not allowed: reads drive be per size too.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, Read_Data=0, rdata_valid=0, misalign=0.
- Reset mid-transaction: mem_req drops immediately (async); outstanding transaction abandoned; late mem_rvalid ignored.
- Min store: op in cycle 0, req in cycle 1 with gnt, DONE cycle 2 → stall high cycles 0-1.
- Min load: gnt cycle 1, rvalid cycle 2, DONE cycle 3, Read_Data/rdata_valid visible cycle 3.
- Each extra cycle of gnt or rvalid latency adds one stall cycle; no limit.
- One outstanding transaction; no pipelining of requests.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 → no bus request; IDLE→DONE directly, misalign pulses in DONE, rdata_valid stays 0, Read_Data unchanged, stall high one cycle.
- Undefined: misalign tied 0; addr low bits dropped for size (half uses addr[1], word ignores addr[1:0]); access proceeds aligned.

## Test plan
- SW 0xDEADBEEF to 0x100, gnt immediate → mem_addr=0x100, be=1111, wdata=0xDEADBEEF, stall 2 cycles.
- SB 0x...A5 to 0x103 → be=1000, wdata=0xA5A5A5A5; then LB 0x103 with rdata 0xA5000000 → Read_Data=0xFFFFFFA5; LBU → 0x000000A5.
- LH 0x102, gnt delayed 3 cycles, rvalid 2 cycles later with 0x80010000 → Read_Data=0xFFFF8001, mem_req stable throughout, stall released only in DONE.
- MemRead and MemWrite both 1 → mem_we=1, no rdata_valid.
- reset driven 0 while in WAIT → mem_req=0 same cycle, following mem_rvalid ignored, Read_Data=0.
- With LSU_MISALIGN_TRAP_EN: LW 0x101 → misalign pulse, mem_req never asserted; without: mem_addr=0x100, be=1111.
